// File: rtl/result_drain_unit.sv
// Result drain unit: reads N*N accelerator results, rounds/narrows them and streams them out through a credit-managed FIFO.
// Optional macro RESULT_DRAIN_SAT_EN selects saturation instead of wrap when narrowing.
module result_drain_unit #(
  parameter int N           = 4,
  parameter int ACCUM_WIDTH = 40,
  parameter int OUT_WIDTH   = 16,
  parameter int SHIFT       = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          acc_done,
  output logic [7:0]                    read_addr,
  input  logic signed [ACCUM_WIDTH-1:0] read_data_c,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic [7:0]                    out_index,
  output logic                          out_last,
  output logic                          busy,
  output logic                          drain_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0] LAST = 8'(N * N - 1);
  localparam logic signed [ACCUM_WIDTH:0] RND =
    (SHIFT > 0) ? (ACCUM_WIDTH+1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
`ifdef RESULT_DRAIN_SAT_EN
  localparam logic signed [ACCUM_WIDTH:0] SAT_MAX =
    $signed(((ACCUM_WIDTH+1)'(1) << (OUT_WIDTH - 1)) - (ACCUM_WIDTH+1)'(1));
  localparam logic signed [ACCUM_WIDTH:0] SAT_MIN = ~SAT_MAX;
`endif

  // Round half up, arithmetic shift, then saturate or wrap to the output width.
  function automatic logic signed [OUT_WIDTH-1:0] round_narrow(
    input logic signed [ACCUM_WIDTH-1:0] x
  );
    logic signed [ACCUM_WIDTH:0] sh;
    sh = ($signed({x[ACCUM_WIDTH-1], x}) + RND) >>> SHIFT;
`ifdef RESULT_DRAIN_SAT_EN
    if (sh > SAT_MAX) return OUT_WIDTH'(SAT_MAX);
    if (sh < SAT_MIN) return OUT_WIDTH'(SAT_MIN);
    return OUT_WIDTH'(sh);
`else
    return OUT_WIDTH'(sh);
`endif
  endfunction

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

  state_t                       state_q, state_d;
  logic                         acc_prev;
  logic                         start, issue_en, push, pop;
  logic [7:0]                   addr_cnt;
  logic                         vld_p0, vld_p1;
  logic [7:0]                   idx_p1;
  logic [CW-1:0]                count, occ;
  logic [PW-1:0]                wr_ptr, rd_ptr;
  logic signed [OUT_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
  logic [7:0]                   fifo_idx  [FIFO_DEPTH];

  // Credit: entries held plus reads still in the pipe must leave room for every issued read.
  assign occ  = count + CW'(vld_p0) + CW'(vld_p1);
  assign push = vld_p1;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    issue_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_done && !acc_prev) begin
          start   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (occ < CW'(FIFO_DEPTH)) begin
          issue_en = 1'b1;
          if (addr_cnt == LAST) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (pop && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_prev   <= 1'b1;
      addr_cnt   <= '0;
      read_addr  <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drain_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_prev <= acc_done;
      if (start)         addr_cnt <= '0;
      else if (issue_en) addr_cnt <= addr_cnt + 8'd1;
      if (issue_en) read_addr <= addr_cnt;
      // p0: address on the memory bus; p1: its data on read_data_c
      vld_p0     <= issue_en;
      vld_p1     <= vld_p0;
      count      <= count + CW'(push) - CW'(pop);
      wr_ptr     <= wr_ptr + PW'(push);
      rd_ptr     <= rd_ptr + PW'(pop);
      drain_done <= pop && out_last;
    end
  end

  always_ff @(posedge clk) begin
    idx_p1 <= read_addr;
    if (push) begin
      fifo_data[wr_ptr] <= round_narrow(read_data_c);
      fifo_idx[wr_ptr]  <= idx_p1;
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_index = out_valid ? fifo_idx[rd_ptr] : '0;
  assign out_last  = out_valid && (fifo_idx[rd_ptr] == LAST);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_result_drain_unit.sv
// Bench for result_drain_unit: two instances (SHIFT=0 and SHIFT=2) share stimulus and are scored
// against an arithmetic model of the rounding/narrowing rules and the in-order stream contract.
module tb_result_drain_unit;
  localparam int N  = 4;
  localparam int NN = N * N;
  localparam int AW = 40;
  localparam int OW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, acc_done, out_ready;
  logic signed [AW-1:0] rd0, rd2;
  logic [1:0]           ov, ol, dd, bz;
  logic [1:0][7:0]      oi, ra;
  logic [1:0][OW-1:0]   od;
  logic signed [AW-1:0] mem [256];

  result_drain_unit #(.N(N), .ACCUM_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .acc_done(acc_done), .read_addr(ra[0]), .read_data_c(rd0),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_index(oi[0]),
    .out_last(ol[0]), .busy(bz[0]), .drain_done(dd[0]));

  result_drain_unit #(.N(N), .ACCUM_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(2), .FIFO_DEPTH(4)) dut_s2 (
    .clk(clk), .reset(reset), .acc_done(acc_done), .read_addr(ra[1]), .read_data_c(rd2),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_index(oi[1]),
    .out_last(ol[1]), .busy(bz[1]), .drain_done(dd[1]));

  // Synchronous result memory: data appears one cycle after the address.
  always @(posedge clk) begin
    rd0 <= mem[ra[0]];
    rd2 <= mem[ra[1]];
  end

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     exp_idx [2], rx [2], done_cnt [2], fv [2], last_cyc [2];
  logic   prev_v [2];
  logic   prev_r;
  logic [OW-1:0] prev_d [2];
  logic [7:0]    prev_i [2];
  longint got [2][NN];

  task automatic check(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic longint exp_val(input longint x, input int sh);
    longint v;
    v = x;
    if (sh > 0) v = v + (64'sd1 <<< (sh - 1));
    v = v >>> sh;
`ifdef RESULT_DRAIN_SAT_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`else
    v = ((v % 65536) + 65536) % 65536;
    if (v >= 32768) v = v - 65536;
`endif
    return v;
  endfunction

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      exp_idx[k] = 0; rx[k] = 0; done_cnt[k] = 0; fv[k] = -1; last_cyc[k] = -100;
      prev_v[k] = 1'b0;
    end
  endtask

  // Observe one cycle at the falling edge, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (prev_v[k] && !prev_r) begin
        check("hold_valid", longint'(ov[k]), 1);
        check("hold_data", longint'($signed(od[k])), longint'($signed(prev_d[k])));
        check("hold_index", longint'(oi[k]), longint'(prev_i[k]));
      end
      if (ov[k] && fv[k] < 0) fv[k] = cyc;
      if (ov[k] && out_ready) begin
        check("index", longint'(oi[k]), exp_idx[k]);
        check("data", longint'($signed(od[k])), exp_val(mem[exp_idx[k] % NN], (k == 0) ? 0 : 2));
        check("last", longint'(ol[k]), longint'(exp_idx[k] == NN - 1));
        got[k][exp_idx[k] % NN] = longint'($signed(od[k]));
        exp_idx[k]++;
        rx[k]++;
        last_cyc[k] = cyc;
      end
      if (dd[k]) begin
        done_cnt[k]++;
        check("done_latency", cyc - last_cyc[k], 1);
      end
      prev_v[k] = ov[k];
      prev_d[k] = od[k];
      prev_i[k] = oi[k];
    end
    prev_r = out_ready;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    logic [63:0] r;
    for (int i = 0; i < NN; i++) begin
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 2))
        0:       mem[i] = AW'($signed(r[11:0]));
        1:       mem[i] = AW'($signed(r[23:0]));
        default: mem[i] = r[AW-1:0];
      endcase
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low 10 cycles after first valid,
  // 3: extra acc_done rising edge while issuing
  task automatic run_drain(input int mode);
    int ec;
    clear_mon();
    out_ready = (mode != 2);
    acc_done = 1'b0;
    tick();
    acc_done = 1'b1;
    ec = cyc;
    for (int t = 0; t < 400 && !(done_cnt[0] > 0 && done_cnt[1] > 0); t++) begin
      if (mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      if (mode == 2) begin
        out_ready = (fv[0] >= 0 && cyc >= fv[0] + 10);
        if (fv[0] >= 0 && cyc == fv[0] + 9) begin
          check("stall_addr0", longint'(ra[0]), 3);
          check("stall_addr1", longint'(ra[1]), 3);
          check("stall_no_xfer", rx[0], 0);
          check("stall_valid", longint'(ov[0]), 1);
        end
      end
      if (mode == 3) begin
        if (cyc == ec + 3) acc_done = 1'b0;
        if (cyc == ec + 5) acc_done = 1'b1;
      end
      tick();
    end
    check("drain_complete", longint'(done_cnt[0] > 0 && done_cnt[1] > 0), 1);
    out_ready = 1'b1;
    for (int t = 0; t < 8; t++) tick();
    for (int k = 0; k < 2; k++) begin
      check("word_count", rx[k], NN);
      check("done_pulses", done_cnt[k], 1);
      check("first_valid_latency_ok", longint'(fv[k] - ec - 1 >= 3), 1);
      check("busy_after", longint'(bz[k]), 0);
    end
  endtask

  task automatic check_cleared(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_valid"}, longint'(ov[k]), 0);
      check({tag, "_data"}, longint'(od[k]), 0);
      check({tag, "_index"}, longint'(oi[k]), 0);
      check({tag, "_last"}, longint'(ol[k]), 0);
      check({tag, "_busy"}, longint'(bz[k]), 0);
      check({tag, "_done"}, longint'(dd[k]), 0);
      check({tag, "_addr"}, longint'(ra[k]), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b1;
    acc_done = 1'b1;
    out_ready = 1'b1;
    prev_r = 1'b1;
    clear_mon();
    tick();
    tick();
    check_cleared("reset");
    reset = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    check("no_start_high_acc", rx[0] + rx[1], 0);
    check("idle_busy", longint'(bz[0]), 0);

    // Matrix product of A = B = 0..15 in row-major order.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint s;
        s = 0;
        for (int k = 0; k < N; k++) s += longint'(i * N + k) * longint'(k * N + j);
        mem[i * N + j] = AW'(s);
      end
    run_drain(0);
    check("c00", got[0][0], 56);
    check("c33", got[0][NN-1], 506);

    fill_random();
    mem[0] = 100000;
    mem[1] = -100000;
    mem[2] = 6;
    mem[3] = -6;
    run_drain(0);
`ifdef RESULT_DRAIN_SAT_EN
    check("sat_pos", got[0][0], 32767);
    check("sat_neg", got[0][1], -32768);
`else
    check("wrap_pos", got[0][0], -31072);
    check("wrap_neg", got[0][1], 31072);
`endif
    check("round_pos", got[1][2], 2);
    check("round_neg", got[1][3], -1);

    fill_random(); run_drain(1);
    fill_random(); run_drain(2);
    fill_random(); run_drain(3);

    // Reset while index 5 is presented, with acc_done held high.
    fill_random();
    clear_mon();
    out_ready = 1'b1;
    acc_done = 1'b0;
    tick();
    acc_done = 1'b1;
    for (int t = 0; t < 100 && !(ov[0] && oi[0] == 8'd5); t++) tick();
    check("reached_index5", longint'(ov[0] && oi[0] == 8'd5), 1);
    reset = 1'b1;
    #1;
    check_cleared("midreset");
    tick();
    reset = 1'b0;
    clear_mon();
    for (int t = 0; t < 12; t++) tick();
    check("no_restart", rx[0] + rx[1], 0);
    check("no_restart_busy", longint'(bz[0] | bz[1]), 0);
    run_drain(0);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_drain(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/result_drain_unit.md
RESULT_DRAIN_UNIT -- requirements
Module: result_drain_unit

Interface
REQ-001 SHALL have parameter N, default 4, matrix dimension; N*N results per drain, N*N <= 256.
REQ-002 SHALL have parameter ACCUM_WIDTH, default 40, signed width of accelerator result words.
REQ-003 SHALL have parameter OUT_WIDTH, default 16, signed width of streamed output words.
REQ-004 SHALL have parameter SHIFT, default 0, arithmetic right-shift amount applied before narrowing; 0 <= SHIFT < ACCUM_WIDTH.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, output FIFO entries; power of two, >= 2.
REQ-006 SHALL have port clk, input, 1, single clock, rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port acc_done, input, 1, accelerator completion level.
REQ-009 SHALL have port read_addr, output, 8, result-memory address (row-major i*N+j).
REQ-010 SHALL have port read_data_c, input, ACCUM_WIDTH signed, result word, valid one cycle after read_addr.
REQ-011 SHALL have ports out_valid output 1, out_ready input 1, out_data output OUT_WIDTH signed, out_index output 8, out_last output 1: the output stream.
REQ-012 SHALL have port busy, output, 1, high from drain start to last handshake.
REQ-013 SHALL have port drain_done, output, 1, one-cycle pulse on completion.

Function
REQ-014 SHALL use FSM states IDLE, ISSUE, FLUSH; IDLE->ISSUE on acc_done rising edge (acc_done high, previous sample low).
REQ-015 SHALL ignore acc_done edges outside IDLE.
REQ-016 SHALL, in ISSUE, drive registered read_addr 0..N*N-1 in order, advancing one address per cycle only when FIFO occupancy plus in-flight reads < FIFO_DEPTH.
REQ-017 SHALL capture read_data_c exactly one cycle after each issued address and push it, with its index, into the FIFO that cycle.
REQ-018 SHALL enter FLUSH after issuing address N*N-1 and return to IDLE on the handshake of index N*N-1.
REQ-019 SHALL present first out_valid no earlier than 3 cycles after the clock edge that samples the acc_done rising edge.
REQ-020 SHALL transfer a word when out_valid && out_ready; out_data/out_index/out_last SHALL hold stable while out_valid && !out_ready.
REQ-021 SHALL never overflow the FIFO (credit rule, REQ-016) and never assert out_valid when empty.
REQ-022 SHALL allow simultaneous push and pop, including when full; occupancy unchanged.
REQ-023 SHALL assert out_last with index N*N-1 only; drain_done SHALL pulse the cycle after that handshake.
REQ-024 SHALL compute out_data: if SHIFT>0 add 2^(SHIFT-1), then arithmetic right-shift by SHIFT (round half up), then narrow per REQ-028.
REQ-025 SHALL emit results in strictly increasing index order with no drops or duplicates.

Reset
REQ-026 SHALL, on reset asserted, immediately force state IDLE, FIFO empty, read_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, drain_done=0, edge-detect history=1 (no false edge from an already-high acc_done).
REQ-027 SHALL, on reset mid-drain, discard all pending results; next drain requires a fresh acc_done rising edge.

Configuration
REQ-028 SHALL, with macro RESULT_DRAIN_SAT_EN defined, saturate shifted value to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; without it, SHALL take the low OUT_WIDTH bits (wrap).

Verification
REQ-029 SHALL cover: A=B=0..15 loaded, accelerator run, out_ready=1, SHIFT=0 -> 16 words, C[0][0]=56 at index 0, C[3][3]=506 with out_last at index 15, one drain_done pulse.
REQ-030 SHALL cover: read_data_c=100000 / -100000, OUT_WIDTH=16 -> 32767 / -32768 with RESULT_DRAIN_SAT_EN; -31072 / 31072 without.
REQ-031 SHALL cover: SHIFT=2, read_data_c=6 / -6 -> out_data 2 / -1.
REQ-032 SHALL cover: out_ready low for 10 cycles after first valid -> read_addr stalls after 4 issued addresses, later all 16 words delivered in order, no loss.
REQ-033 SHALL cover: reset asserted at output index 5 with acc_done still high -> outputs cleared same cycle, no drain restarts until acc_done falls and rises again.
REQ-034 SHALL cover: second acc_done rising edge during ISSUE -> ignored, exactly 16 words and one drain_done.
